// File: rtl/button_pulse_gen.sv
// Push-button front end: synchroniser, debounce FSM and auto-repeat, producing
// single-cycle count-enable pulses plus the debounced level.
module button_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic ce_out,
    output logic btn_level,
    output logic repeating
);

    // state      | meaning
    // IDLE       | button released and stable
    // PRESS_DB   | counting consecutive pressed samples
    // PRESSED    | press accepted, hold timer runs while repeat_en=1
    // REPEAT     | auto-repeat active, pulse every REPEAT_PERIOD cycles
    // RELEASE_DB | counting consecutive released samples, level still 1
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_PRESSED,
        ST_REPEAT,
        ST_RELEASE_DB
    } state_t;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam int REP_W  = $clog2(REPEAT_PERIOD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;

    state_t              state_q, state_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic                ce_q, ce_d;
    logic                level_q, level_d;
    logic                repeating_q, repeating_d;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            ce_q        <= 1'b0;
            level_q     <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_in};
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            ce_q        <= ce_d;
            level_q     <= level_d;
            repeating_q <= repeating_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        ce_d       = 1'b0;
        level_d    = level_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = ST_PRESSED;
                        ce_d       = 1'b1;
                        level_d    = 1'b1;
                        db_cnt_d   = '0;
                        hold_cnt_d = '0;
                    end else begin
                        state_d  = ST_PRESS_DB;
                        db_cnt_d = DB_W'(1);
                    end
                end
            end

            ST_PRESS_DB: begin
                if (!btn_s) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = ST_PRESSED;
                    ce_d       = 1'b1;
                    level_d    = 1'b1;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            ST_PRESSED: begin
                if (!btn_s) begin
                    hold_cnt_d = '0;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d  = ST_IDLE;
                        level_d  = 1'b0;
                        db_cnt_d = '0;
                    end else begin
                        state_d  = ST_RELEASE_DB;
                        db_cnt_d = DB_W'(1);
                    end
                end else if (repeat_en) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_REPEAT;
                        ce_d       = 1'b1;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else begin
                    hold_cnt_d = '0;
                end
            end

            ST_REPEAT: begin
                // A release on the same edge as a due repeat pulse suppresses the pulse.
                if (!btn_s) begin
                    rep_cnt_d = '0;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d  = ST_IDLE;
                        level_d  = 1'b0;
                        db_cnt_d = '0;
                    end else begin
                        state_d  = ST_RELEASE_DB;
                        db_cnt_d = DB_W'(1);
                    end
                end else if (!repeat_en) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    ce_d      = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end

            ST_RELEASE_DB: begin
                if (btn_s) begin
                    state_d    = ST_PRESSED;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_IDLE;
                    level_d  = 1'b0;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                db_cnt_d   = '0;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
                level_d    = 1'b0;
            end
        endcase

        repeating_d = (state_d == ST_REPEAT);
    end

    assign ce_out    = ce_q;
    assign btn_level = level_q;
    assign repeating = repeating_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench for button_pulse_gen: expected pulse edges are queued from the
// latency formulas when stimulus is applied and matched against observed ce_out pulses.
module tb_button_pulse_gen;

    localparam int SYNC  = 2;
    localparam int DB    = 16;
    localparam int DELAY = 64;
    localparam int PER   = 16;
    localparam int LAT   = SYNC + DB - 1;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic repeat_en;
    logic ce_out;
    logic btn_level;
    logic repeating;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int pulse_count = 0;
    int exp_q[$];

    button_pulse_gen #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .ce_out   (ce_out),
        .btn_level(btn_level),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // cyc at the falling edge equals the index of the rising edge that launched ce_out
    always @(negedge clk) begin
        if (ce_out) begin
            int exp_t;
            pulse_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse at_edge=%0d expected=none", cyc);
            end else begin
                exp_t = exp_q.pop_front();
                if (cyc !== exp_t) begin
                    failures++;
                    $display("FAIL pulse_time got_edge=%0d expected_edge=%0d", cyc, exp_t);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_pulses got=%0d expected=0 next_edge=%0d",
                     name, exp_q.size(), exp_q[0]);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_in = 1'b0; repeat_en = 1'b0;
        step(3);
        checks++; if (ce_out !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b expected=0", ce_out); end
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL reset_level got=%b expected=0", btn_level); end
        checks++; if (repeating !== 1'b0) begin failures++; $display("FAIL reset_repeating got=%b expected=0", repeating); end
        rst = 1'b0;
        step(4);
    endtask

    task automatic test_clean_press();
        int t0, t1;
        repeat_en = 1'b0;
        btn_in = 1'b1; t0 = cyc + 1;
        exp_q.push_back(t0 + LAT);
        step_to(t0 + LAT - 1);
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL clean_level_early got=%b expected=0", btn_level); end
        step_to(t0 + LAT);
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL clean_level_set got=%b expected=1", btn_level); end
        step_to(t0 + 59);
        btn_in = 1'b0; t1 = cyc + 1;
        step_to(t1 + LAT - 1);
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL clean_level_hold got=%b expected=1", btn_level); end
        step_to(t1 + LAT);
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL clean_level_clear got=%b expected=0", btn_level); end
        step(10);
        check_drained("clean_press");
    endtask

    task automatic test_bounce();
        int ts;
        repeat_en = 1'b0;
        for (int seg = 0; seg < 10; seg++) begin
            btn_in = (seg % 2 == 0);
            step(3);
        end
        btn_in = 1'b1; ts = cyc + 1;
        exp_q.push_back(ts + LAT);
        step_to(ts + LAT + 20);
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL bounce_level got=%b expected=1", btn_level); end
        btn_in = 1'b0;
        step(30);
        check_drained("bounce");
    endtask

    task automatic test_glitch();
        int t0, pc0;
        pc0 = pulse_count;
        btn_in = 1'b1; t0 = cyc + 1;
        step_to(t0 + 9);
        btn_in = 1'b0;
        step_to(t0 + LAT);
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL glitch_level got=%b expected=0", btn_level); end
        step(40);
        checks++; if (pulse_count !== pc0) begin failures++; $display("FAIL glitch_pulses got=%0d expected=%0d", pulse_count, pc0); end
    endtask

    task automatic test_auto_repeat();
        int t0, t1, e;
        repeat_en = 1'b1;
        btn_in = 1'b1; t0 = cyc + 1;
        e  = t0 + LAT;
        t1 = t0 + 200;
        exp_q.push_back(e);
        // release reaches the FSM SYNC edges after t1; a pulse due on that edge is dropped
        for (int t = e + DELAY; t < t1 + SYNC; t += PER) exp_q.push_back(t);
        step_to(e + DELAY - 1);
        checks++; if (repeating !== 1'b0) begin failures++; $display("FAIL repeat_flag_early got=%b expected=0", repeating); end
        step_to(e + DELAY);
        checks++; if (repeating !== 1'b1) begin failures++; $display("FAIL repeat_flag_set got=%b expected=1", repeating); end
        step_to(t1 - 1);
        btn_in = 1'b0;
        step_to(t1 + SYNC - 1);
        checks++; if (repeating !== 1'b1) begin failures++; $display("FAIL repeat_flag_hold got=%b expected=1", repeating); end
        step_to(t1 + SYNC);
        checks++; if (repeating !== 1'b0) begin failures++; $display("FAIL repeat_flag_clear got=%b expected=0", repeating); end
        step_to(t1 + LAT);
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL repeat_level_clear got=%b expected=0", btn_level); end
        repeat_en = 1'b0;
        step(10);
        check_drained("auto_repeat");
    endtask

    task automatic test_release_glitch();
        int t0, e, g0, gend, t1;
        repeat_en = 1'b1;
        btn_in = 1'b1; t0 = cyc + 1;
        e = t0 + LAT;
        exp_q.push_back(e);
        exp_q.push_back(e + DELAY);
        step_to(e + DELAY + 2);
        btn_in = 1'b0; g0 = cyc + 1;
        step_to(g0 + 4);
        btn_in = 1'b1; gend = cyc + 1;
        t1 = gend + 100;
        for (int t = gend + SYNC + DELAY; t < t1 + SYNC; t += PER) exp_q.push_back(t);
        step_to(g0 + SYNC + 1);
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL rglitch_level_during got=%b expected=1", btn_level); end
        checks++; if (repeating !== 1'b0) begin failures++; $display("FAIL rglitch_repeating got=%b expected=0", repeating); end
        step_to(gend + SYNC + 1);
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL rglitch_level_after got=%b expected=1", btn_level); end
        step_to(t1 - 1);
        btn_in = 1'b0;
        step_to(t1 + LAT + 5);
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL rglitch_level_release got=%b expected=0", btn_level); end
        repeat_en = 1'b0;
        step(5);
        check_drained("release_glitch");
    endtask

    task automatic test_reset_mid_repeat();
        int t0, e, t0p;
        repeat_en = 1'b1;
        btn_in = 1'b1; t0 = cyc + 1;
        e = t0 + LAT;
        exp_q.push_back(e);
        exp_q.push_back(e + DELAY);
        step_to(e + DELAY + 6);
        checks++; if (repeating !== 1'b1) begin failures++; $display("FAIL rstmid_pre_repeating got=%b expected=1", repeating); end
        rst = 1'b1; repeat_en = 1'b0;
        step(2);
        checks++; if (ce_out !== 1'b0) begin failures++; $display("FAIL rstmid_ce got=%b expected=0", ce_out); end
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL rstmid_level got=%b expected=0", btn_level); end
        checks++; if (repeating !== 1'b0) begin failures++; $display("FAIL rstmid_repeating got=%b expected=0", repeating); end
        rst = 1'b0; t0p = cyc + 1;
        exp_q.push_back(t0p + LAT);
        step_to(t0p + LAT - 1);
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL rstmid_level_early got=%b expected=0", btn_level); end
        step_to(t0p + LAT);
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL rstmid_level_set got=%b expected=1", btn_level); end
        btn_in = 1'b0;
        step(30);
        check_drained("reset_mid_repeat");
    endtask

    initial begin
        rst = 1'b1; btn_in = 1'b0; repeat_en = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_release_glitch();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
